// File: rtl/comparator_bist_checker_if.sv
// Test-port bundle between the comparator BIST checker and its surroundings:
// operand drive, comparator flags, and run/status reporting.
interface comparator_bist_checker_if #(
  parameter int NBITS = 2
);
  logic                 start;
  logic [NBITS-1:0]     a_o;
  logic [NBITS-1:0]     b_o;
  logic                 x_i;
  logic                 y_i;
  logic                 z_i;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*NBITS:0]     err_count;
  logic [2*NBITS-1:0]   first_fail_vec;
  logic                 first_fail_valid;

  // master: the checker itself; slave: comparator + status block side
  modport master (
    input  start, x_i, y_i, z_i,
    output a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
  modport slave (
    output start, x_i, y_i, z_i,
    input  a_o, b_o, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/comparator_bist_checker.sv
// Exhaustive sweep of all {A,B} operand pairs into a magnitude comparator,
// checking x/y/z flags against a golden compare and logging error statistics.
module comparator_bist_checker #(
  parameter int NBITS         = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input logic                         clk,
  input logic                         rst_n,
  comparator_bist_checker_if.master   bus
);
  localparam int VW = 2*NBITS;
  localparam int EW = VW+1;
  localparam int CW = $clog2(SETTLE_CYCLES+1);
  localparam logic [VW-1:0] VEC_MAX = '1;
  localparam logic [EW-1:0] ERR_MAX = {1'b1, {VW{1'b0}}};
  localparam logic [CW-1:0] CNT_END = CW'(SETTLE_CYCLES-1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t          state, state_n;
  logic [VW-1:0]   vec, vec_n, ffv, ffv_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [EW-1:0]   err, err_n;
  logic            ffvalid, ffvalid_n, busy, busy_n, done, done_n, pass, pass_n;
  logic            launch, mismatch;
  logic [NBITS-1:0] a, b;

  assign a = vec[VW-1:NBITS];
  assign b = vec[NBITS-1:0];
  // Case-inequality so an X/Z flag counts as a mismatch in simulation
  assign mismatch = ({bus.x_i, bus.y_i, bus.z_i} !== {a > b, a == b, a < b});

  always_comb begin
    state_n   = state;
    vec_n     = vec;
    cnt_n     = cnt;
    err_n     = err;
    ffv_n     = ffv;
    ffvalid_n = ffvalid;
    busy_n    = busy;
    done_n    = done;
    pass_n    = pass;
    launch    = 1'b0;
    case (state)
      IDLE:   launch = bus.start;
      SETTLE: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_END) state_n = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          if (err != ERR_MAX) err_n = err + 1'b1;
          if (!ffvalid) begin
            ffv_n     = vec;
            ffvalid_n = 1'b1;
          end
        end
        if (vec == VEC_MAX) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          vec_n   = vec + 1'b1;
          cnt_n   = '0;
          state_n = SETTLE;
        end
      end
      DONE:   launch = bus.start;
      default: state_n = IDLE;
    endcase
    if (launch) begin
      state_n   = SETTLE;
      vec_n     = '0;
      cnt_n     = '0;
      err_n     = '0;
      ffv_n     = '0;
      ffvalid_n = 1'b0;
      busy_n    = 1'b1;
      done_n    = 1'b0;
      pass_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec     <= '0;
      cnt     <= '0;
      err     <= '0;
      ffv     <= '0;
      ffvalid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state   <= state_n;
      vec     <= vec_n;
      cnt     <= cnt_n;
      err     <= err_n;
      ffv     <= ffv_n;
      ffvalid <= ffvalid_n;
      busy    <= busy_n;
      done    <= done_n;
      pass    <= pass_n;
    end
  end

  assign bus.a_o              = a;
  assign bus.b_o              = b;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass;
  assign bus.err_count        = err;
  assign bus.first_fail_vec   = ffv;
  assign bus.first_fail_valid = ffvalid;
endmodule

// File: tb/tb_comparator_bist_checker.sv
// Drives two checker instances (combinational DUT / one-cycle registered DUT)
// with correct, stuck, swapped and randomly faulted comparator models.
module tb_comparator_bist_checker;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  comparator_bist_checker_if #(.NBITS(2)) b0();
  comparator_bist_checker_if #(.NBITS(2)) b1();

  logic       start0, start1;
  int         mode;
  logic [2:0] fmask [16];
  logic [2:0] r1;
  int         npass = 0, ntot = 0;

  comparator_bist_checker #(.NBITS(2), .SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  comparator_bist_checker #(.NBITS(2), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // Comparator under test: 0 good, 1 y stuck-at-0, 2 x/z swapped, 3 XOR fault mask
  function automatic logic [2:0] cmp_flags(int m, logic [1:0] a, logic [1:0] b, logic [2:0] msk);
    logic [2:0] g;
    g = {a > b, a == b, a < b};
    case (m)
      1:       return {g[2], 1'b0, g[0]};
      2:       return {g[0], g[1], g[2]};
      3:       return g ^ msk;
      default: return g;
    endcase
  endfunction

  assign b0.start = start0;
  assign b1.start = start1;
  assign {b0.x_i, b0.y_i, b0.z_i} = cmp_flags(mode, b0.a_o, b0.b_o, fmask[{b0.a_o, b0.b_o}]);
  always @(posedge clk) r1 <= cmp_flags(mode, b1.a_o, b1.b_o, fmask[{b1.a_o, b1.b_o}]);
  assign {b1.x_i, b1.y_i, b1.z_i} = r1;

  // Reference: walk all vectors, compare the faulty comparator against true ordering
  task automatic model(input int m, output int err, output int ffv, output int ffvalid);
    err = 0; ffv = 0; ffvalid = 0;
    for (int v = 0; v < 16; v++) begin
      int a, b;
      logic [2:0] act, gold;
      a = v / 4; b = v % 4;
      gold = {a > b, a == b, a < b};
      act  = cmp_flags(m, 2'(a), 2'(b), fmask[v]);
      if (act != gold) begin
        err++;
        if (ffvalid == 0) begin ffv = v; ffvalid = 1; end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int st(int sel);
    if (sel == 1) return {b1.a_o, b1.b_o, b1.busy, b1.done, b1.pass, b1.err_count, b1.first_fail_vec, b1.first_fail_valid};
    return {b0.a_o, b0.b_o, b0.busy, b0.done, b0.pass, b0.err_count, b0.first_fail_vec, b0.first_fail_valid};
  endfunction
  function automatic logic get_done(int sel); return sel == 1 ? b1.done : b0.done; endfunction
  function automatic logic get_pass(int sel); return sel == 1 ? b1.pass : b0.pass; endfunction
  function automatic logic get_busy(int sel); return sel == 1 ? b1.busy : b0.busy; endfunction
  function automatic int get_err(int sel); return sel == 1 ? int'(b1.err_count) : int'(b0.err_count); endfunction
  function automatic int get_ffv(int sel); return sel == 1 ? int'(b1.first_fail_vec) : int'(b0.first_fail_vec); endfunction
  function automatic int get_ffvalid(int sel); return sel == 1 ? int'(b1.first_fail_valid) : int'(b0.first_fail_valid); endfunction
  function automatic int get_ab(int sel); return sel == 1 ? int'({b1.a_o, b1.b_o}) : int'({b0.a_o, b0.b_o}); endfunction

  task automatic set_start(int sel, logic v);
    if (sel == 1) start1 = v; else start0 = v;
  endtask

  // Counts edges from the start-accept edge until done rises (bounded)
  task automatic wait_done(input int sel, output int cyc);
    cyc = 0;
    while (!get_done(sel) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input int sel, output int cyc);
    @(negedge clk); set_start(sel, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); set_start(sel, 1'b0);
    #4;
    wait_done(sel, cyc);
  endtask

  typedef struct {
    int sel; int m; int err; int ffv; int ffvalid; int pass; int cyc;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int cyc, e, fv, fvl;
    tbl[0] = '{0, 0, 0,  0, 0, 1, 48};
    tbl[1] = '{0, 1, 4,  0, 1, 0, 48};
    tbl[2] = '{0, 2, 12, 1, 1, 0, 48};
    tbl[3] = '{1, 0, 0,  0, 0, 1, 32};
    tbl[4] = '{1, 1, 4,  0, 1, 0, 32};
    tbl[5] = '{1, 2, 12, 1, 1, 0, 32};
    for (int i = 0; i < 16; i++) fmask[i] = 3'b000;
    mode = 0; start0 = 0; start1 = 0;
    rst_n = 0;
    #1;
    chk("reset_state0", st(0), 0);
    chk("reset_state1", st(1), 0);
    #20 @(negedge clk) rst_n = 1;

    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].m;
      run(tbl[i].sel, cyc);
      chk($sformatf("t%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("t%0d_err", i), get_err(tbl[i].sel), tbl[i].err);
      chk($sformatf("t%0d_ffv", i), get_ffv(tbl[i].sel), tbl[i].ffv);
      chk($sformatf("t%0d_ffvalid", i), get_ffvalid(tbl[i].sel), tbl[i].ffvalid);
      chk($sformatf("t%0d_pass", i), int'(get_pass(tbl[i].sel)), tbl[i].pass);
      chk($sformatf("t%0d_busy", i), int'(get_busy(tbl[i].sel)), 0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("t%0d_ab_hold", i), get_ab(tbl[i].sel), 15);
      chk($sformatf("t%0d_done_hold", i), int'(get_done(tbl[i].sel)), 1);
    end

    // Mid-sweep asynchronous reset with errors already logged
    mode = 1;
    @(negedge clk); start0 = 1;
    @(posedge clk); #1;
    @(negedge clk); start0 = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_err_before_rst", get_err(0), 2);
    chk("mid_busy_before_rst", int'(b0.busy), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_zero", st(0), 0);
    @(negedge clk) rst_n = 1;
    mode = 0;
    run(0, cyc);
    chk("post_rst_cycles", cyc, 48);
    chk("post_rst_pass", int'(b0.pass), 1);

    // Start held through the sweep, then still high in DONE -> rerun
    @(negedge clk); start0 = 1;
    @(posedge clk); #1;
    wait_done(0, cyc);
    chk("held_cycles", cyc, 48);
    chk("held_pass", int'(b0.pass), 1);
    @(posedge clk); #1;
    chk("restart_done", int'(b0.done), 0);
    chk("restart_pass", int'(b0.pass), 0);
    chk("restart_busy", int'(b0.busy), 1);
    chk("restart_ab", get_ab(0), 0);
    @(negedge clk); start0 = 0;
    #4;
    wait_done(0, cyc);
    chk("rerun_cycles", cyc, 48);
    chk("rerun_pass", int'(b0.pass), 1);

    // Randomized fault masks against the reference walk
    mode = 3;
    for (int it = 0; it < 6; it++) begin
      int sel;
      sel = it % 2;
      for (int v = 0; v < 16; v++)
        fmask[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      model(3, e, fv, fvl);
      run(sel, cyc);
      chk($sformatf("rnd%0d_cycles", it), cyc, sel == 1 ? 32 : 48);
      chk($sformatf("rnd%0d_err", it), get_err(sel), e);
      chk($sformatf("rnd%0d_ffvalid", it), get_ffvalid(sel), fvl);
      chk($sformatf("rnd%0d_ffv", it), get_ffv(sel), fv);
      chk($sformatf("rnd%0d_pass", it), int'(get_pass(sel)), e == 0 ? 1 : 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/comparator_bist_checker.md
# comparator_bist_checker

Synthesizable self-test engine for the 2-bit magnitude comparator: it drives every operand pair into the comparator and checks the three result flags against an internal golden model. Its job is the response-checking end of the comparator's test interface. It sits beside the comparator in the BIST wrapper and reports pass/fail, error count and the first failing vector to the status register block.

## Interface
Parameters
- `NBITS`, default 2: operand width; the sweep covers 2^(2·NBITS) vectors.
- `SETTLE_CYCLES`, default 2, minimum 1: cycles each vector is held before its response is sampled.

Ports
- `clk`  in  1  Single clock; all state on its rising edge.
- `rst_n`  in  1  Asynchronous active-low reset.
- `start`  in  1  Run request; sampled in IDLE or DONE, ignored while busy.
- `a_o`  out  NBITS  Operand A to the comparator (A1:A0).
- `b_o`  out  NBITS  Operand B to the comparator (B1:B0).
- `x_i`  in  1  Comparator flag, A>B.
- `y_i`  in  1  Comparator flag, A==B.
- `z_i`  in  1  Comparator flag, A<B.
- `busy`  out  1  Sweep in progress.
- `done`  out  1  Sweep complete; held until the next start or reset.
- `pass`  out  1  Valid with `done`; 1 iff `err_count`==0.
- `err_count`  out  2·NBITS+1  Number of mismatching vectors.
- `first_fail_vec`  out  2·NBITS  Vector index {A,B} of the first mismatch.
- `first_fail_valid`  out  1  `first_fail_vec` holds a captured value.

## Operation
- Vector register `vec` is 2·NBITS bits wide.
  - `a_o = vec[2·NBITS-1:NBITS]`, `b_o = vec[NBITS-1:0]`.
  - Both are registered outputs; the sweep order is ascending 0..2^(2·NBITS)-1.
- Golden model: `exp_x = a_o>b_o`, `exp_y = a_o==b_o`, `exp_z = a_o<b_o` (unsigned).
  - Mismatch if any of x/y/z differs from its expected bit.
  - In simulation an X or Z on a sampled flag counts as a mismatch.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - `vec`=0, `busy`=0.
  - `start`=1 → clear `err_count`, `first_fail_valid` and `first_fail_vec`; `vec`=0, settle counter=0, `busy`=1 → SETTLE.
- SETTLE:
  - Settle counter increments each cycle.
  - When the counter reaches `SETTLE_CYCLES`-1 → CHECK. SETTLE therefore lasts exactly `SETTLE_CYCLES` cycles.
- CHECK, one cycle; compare flags against the golden model. On mismatch:
  - `err_count` += 1, saturating at 2^(2·NBITS).
  - If `first_fail_valid`=0, capture `first_fail_vec`=`vec` and set `first_fail_valid`=1.
- Leaving CHECK:
  - `vec` at its maximum (all ones) → DONE. `vec` does not wrap; it holds its last value.
  - Otherwise `vec`+1, settle counter=0 → SETTLE.
- DONE:
  - `busy`=0, `done`=1, `pass` = (`err_count`==0, including the final CHECK's result).
  - Results and `a_o`/`b_o` hold.
  - `start`=1 → same actions as start from IDLE, plus `done`=0, `pass`=0.
- `start` while busy has no effect.

## Timing
- Reset values: `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_valid`=0; state=IDLE.
- Reset asserted mid-sweep aborts immediately (asynchronous) to the reset values.
- Start accepted at rising edge k: `busy`=1 and `a_o`/`b_o`=0 after edge k.
- Vector v is driven from edge k+v·(`SETTLE_CYCLES`+1). Its flags are sampled at edge k+(v+1)·(`SETTLE_CYCLES`+1).
- `done`=1 after edge k+2^(2·NBITS)·(`SETTLE_CYCLES`+1); `busy` falls on the same edge.
  - Defaults: 48 cycles.
  - `SETTLE_CYCLES`=1: 32 cycles.
- DUT may be combinational, or registered with latency ≤ `SETTLE_CYCLES`.
- A mismatch at CHECK updates `err_count` and `first_fail_*` on that CHECK edge.

## Test plan
- Correct combinational comparator, defaults, start pulse → `done` at cycle 48, `pass`=1, `err_count`=0, `first_fail_valid`=0, `a_o`=3, `b_o`=3 held.
- DUT with `y` stuck at 0 → `err_count`=4, `first_fail_vec`=0, `first_fail_valid`=1, `pass`=0.
- DUT with `x` and `z` swapped → `err_count`=12, `first_fail_vec`=1 (A=0, B=1), `pass`=0.
- Reset pulsed at cycle 20 of a sweep → all outputs are zero immediately. A new start then completes in 48 cycles with `pass`=1.
- `start` held high during the sweep → no restart, `done` still at cycle 48. `start` in DONE → `done`/`pass`/`err_count` clear on the next edge and the sweep reruns.
- `SETTLE_CYCLES`=1 with a one-cycle registered correct DUT → `done` at cycle 32, `pass`=1.
